// File: rtl/agc_gain_pkg.sv
// agc_gain_pkg: FSM encoding, gain code limits and arithmetic helpers for the AGC gain controller
package agc_gain_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;
    localparam logic [2:0] S_ADJUST = 3'd5;

    localparam logic signed [8:0] GAIN_MIN = -9'sd40;
    localparam logic signed [8:0] GAIN_MAX = 9'sd40;

    typedef enum logic [1:0] {STEP_HOLD, STEP_DEC, STEP_INC} step_t;

    // -2048 has no positive 12-bit counterpart, so it folds to 2047
    function automatic logic [10:0] sat_abs12(input logic signed [11:0] x);
        logic [11:0] n;
        n = -x;
        return !x[11] ? x[10:0] : (n[11] ? 11'h7FF : n[10:0]);
    endfunction

    function automatic logic signed [8:0] clamp_gain(input logic signed [9:0] g);
        return g < 10'(GAIN_MIN) ? GAIN_MIN : g > 10'(GAIN_MAX) ? GAIN_MAX : g[8:0];
    endfunction

endpackage

// File: rtl/agc_gain_controller_peak_window_tracker.sv
// peak_window_tracker: per-window |result| peak, result count and threshold step decision
module peak_window_tracker
    import agc_gain_pkg::*;
#(
    parameter int WINDOW_LEN  = 256,
    parameter int HIGH_THRESH = 1843,
    parameter int LOW_THRESH  = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        update,
    input  logic [11:0] result,
    output logic        window_end,
    output step_t       step
);

    localparam int CW = $clog2(WINDOW_LEN);

    logic [CW-1:0] count;
    logic [10:0]   peak;
    logic [10:0]   mag;

    always_comb begin
        mag        = sat_abs12(result);
        window_end = update && count == CW'(WINDOW_LEN - 1);
        step       = peak > 11'(HIGH_THRESH) ? STEP_DEC : peak < 11'(LOW_THRESH) ? STEP_INC : STEP_HOLD;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            peak  <= '0;
            count <= '0;
        end else if (update) begin
            peak  <= mag > peak ? mag : peak;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/agc_gain_controller.sv
// agc_gain_controller: start/done initiator for the gain stage with per-window automatic gain control.
// Optional done watchdog enabled by defining AGC_GAIN_CTRL_TIMEOUT_EN.
module agc_gain_controller
    import agc_gain_pkg::*;
#(
    parameter int              WINDOW_LEN  = 256,
    parameter int              HIGH_THRESH = 1843,
    parameter int              LOW_THRESH  = 512,
    parameter int              STEP_DOWN   = 4,
    parameter int              STEP_UP     = 1,
    parameter logic signed [8:0] INIT_GAIN = 9'sd0
`ifdef AGC_GAIN_CTRL_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYCLES = 64
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [11:0]        sample_in,
    input  logic               agc_enable,
    input  logic signed [8:0]  manual_gain,
    output logic               gain_start,
    output logic [11:0]        gain_sample,
    output logic signed [8:0]  gain_value,
    input  logic               gain_done,
    input  logic [11:0]        gain_result,
    output logic               out_valid,
    output logic [11:0]        out_sample,
    output logic signed [8:0]  current_gain,
    output logic               overrun,
    output logic [7:0]         overrun_count,
    output logic               timeout_err
);

    logic [2:0]        state;
    logic              hold_valid;
    logic [11:0]       hold_data;
    logic [11:0]       result_q;
    logic              emit_raw;
    logic              timed_out;
    logic              window_end;
    logic              busy;
    logic              drop;
    logic              load_hold;
    step_t             step;
    logic signed [8:0] issue_gain;
    logic signed [8:0] adj_gain;
    logic signed [9:0] cur_ext;

    always_comb begin
        busy       = state != S_IDLE;
        drop       = busy && sample_valid && hold_valid;
        // in IDLE a full buffer is issued, so an arriving sample refills it
        load_hold  = sample_valid && (busy ? !hold_valid : hold_valid);
        issue_gain = agc_enable ? current_gain : clamp_gain({manual_gain[8], manual_gain});
        cur_ext    = {current_gain[8], current_gain};
        adj_gain   = clamp_gain(step == STEP_DEC ? cur_ext - 10'(STEP_DOWN) :
                                step == STEP_INC ? cur_ext + 10'(STEP_UP) : cur_ext);
        gain_start = state == S_ISSUE;
        out_valid  = state == S_EMIT;
        out_sample = result_q;
    end

`ifdef AGC_GAIN_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    always_comb timed_out = state == S_WAIT && !gain_done && wait_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt    <= state == S_WAIT ? wait_cnt + 1'b1 : '0;
            timeout_err <= timeout_err | timed_out;
        end
    end
`else
    always_comb begin
        timed_out   = 1'b0;
        timeout_err = 1'b0;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            hold_valid    <= 1'b0;
            hold_data     <= '0;
            gain_sample   <= '0;
            gain_value    <= '0;
            current_gain  <= INIT_GAIN;
            result_q      <= '0;
            emit_raw      <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            overrun       <= drop;
            overrun_count <= drop && overrun_count != 8'hFF ? overrun_count + 1'b1 : overrun_count;
            hold_valid    <= busy ? hold_valid || sample_valid : hold_valid && sample_valid;
            hold_data     <= load_hold ? sample_in : hold_data;
            case (state)
                S_IDLE: begin
                    if (hold_valid || sample_valid) begin
                        gain_sample  <= hold_valid ? hold_data : sample_in;
                        gain_value   <= issue_gain;
                        current_gain <= issue_gain;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_ARM;
                // a level done left over from the previous operation is still visible here
                S_ARM:   state <= S_WAIT;
                S_WAIT: begin
                    if (gain_done || timed_out) begin
                        result_q <= gain_done ? gain_result : gain_sample;
                        emit_raw <= !gain_done;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT:  state <= window_end && agc_enable ? S_ADJUST : S_IDLE;
                S_ADJUST: begin
                    current_gain <= adj_gain;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    peak_window_tracker #(
        .WINDOW_LEN (WINDOW_LEN),
        .HIGH_THRESH(HIGH_THRESH),
        .LOW_THRESH (LOW_THRESH)
    ) u_tracker (
        .clock     (clock),
        .reset     (reset),
        .clear     (!agc_enable || state == S_ADJUST),
        .update    (state == S_EMIT && !emit_raw),
        .result    (result_q),
        .window_end(window_end),
        .step      (step)
    );

endmodule
